instr_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the single-cycle RISC-V core. Holds the PC, drives the word address into the asynchronous instruction ROM, and passes the returned word to decode. Selects the next PC from sequential, redirect (branch/JAL/JALR) or hold. Runs a RUN/HALT/FAULT state machine that stops the core on the exit `ecall` or on a bad fetch address.

---
 rtl/instr_fetch_unit.sv | 58 +++++
 tb/tb_instr_fetch_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, ROM fetch and RUN/HALT/FAULT control; FETCH_RETIRE_CNT_EN builds the retired-instruction counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_target,
  input  logic              ecall,
  input  logic [31:0]       a7,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       retired
);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  state_t state;
  logic [31:0] cand;
  logic exit_call, bad;
  assign rom_addr  = pc[ADDR_W+1:2];
  assign pc_plus4  = pc + 32'd4;
  assign instr     = (state == RUN) ? rom_data : 32'h0000_0013;
  assign exit_call = ecall && a7 == 32'd10;
  assign cand      = redirect_en ? (redirect_target & ~32'd1) : pc_plus4;
  assign bad       = cand[1] || (cand >> (ADDR_W + 2)) != 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (state == RUN) begin
      if (exit_call) begin
        state  <= HALT;
        halted <= 1'b1;
      end else if (!stall) begin
        if (bad) begin
          state <= FAULT;
          fault <= 1'b1;
        end else pc <= cand;
      end
    end
  end
`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) retired <= 32'd0;
    else if (state == RUN && !stall) retired <= retired + 32'd1;
  end
`else
  assign retired = 32'd0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst, stall, redirect_en, ecall;
  logic [31:0] redirect_target, a7, rom_data, instr, pc, pc_plus4, retired;
  logic [19:0] rom_addr;
  logic halted, fault;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .ecall(ecall), .a7(a7),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .pc(pc),
    .pc_plus4(pc_plus4), .halted(halted), .fault(fault), .retired(retired)
  );
  assign rom_data = 32'h0020_0293 ^ {rom_addr, 12'h000};
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h0020_0293 ^ {a[21:2], 12'h000};
  endfunction
  function automatic logic [31:0] ret(input logic [31:0] n);
`ifdef FETCH_RETIRE_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_at(input string tag, input logic [31:0] p);
    chk({tag, " pc"}, pc, p);
    chk({tag, " rom_addr"}, {12'h0, rom_addr}, {12'h0, p[21:2]});
    chk({tag, " pc_plus4"}, pc_plus4, p + 32'd4);
    chk({tag, " instr"}, instr, rom_word(p));
    chk({tag, " halted"}, {31'h0, halted}, 32'd0);
    chk({tag, " fault"}, {31'h0, fault}, 32'd0);
  endtask
  task automatic stopped(input string tag, input logic [31:0] p, input logic h);
    chk({tag, " pc"}, pc, p);
    chk({tag, " instr"}, instr, 32'h0000_0013);
    chk({tag, " halted"}, {31'h0, halted}, {31'h0, h});
    chk({tag, " fault"}, {31'h0, fault}, {31'h0, !h});
  endtask
  initial begin
    rst = 1; stall = 0; redirect_en = 0; redirect_target = 0; ecall = 0; a7 = 0;
    step(); step();
    run_at("reset", 32'h0);
    chk("reset instr word0", instr, 32'h0020_0293);
    chk("reset retired", retired, 32'd0);
    rst = 0;
    step(); run_at("seq1", 32'h4);
    step(); run_at("seq2", 32'h8);
    chk("seq retired", retired, ret(2));
    stall = 1; redirect_en = 1; redirect_target = 32'h31;
    step(); run_at("stall1", 32'h8);
    step(); run_at("stall2", 32'h8);
    chk("stall retired", retired, ret(2));
    stall = 0;
    step(); run_at("redirect 31", 32'h30);
    redirect_en = 0;
    step(); run_at("seq34", 32'h34);
    step(); run_at("seq38", 32'h38);
    step(); run_at("seq3c", 32'h3C);
    ecall = 1; a7 = 32'd34;
    step(); run_at("ecall34", 32'h40);
    ecall = 0; redirect_en = 1; redirect_target = 32'h3C;
    step(); run_at("back3c", 32'h3C);
    redirect_en = 0; ecall = 1; a7 = 32'd10;
    step(); stopped("exit", 32'h3C, 1'b1);
    step(); stopped("halt hold", 32'h3C, 1'b1);
    chk("halt retired", retired, ret(9));
    ecall = 0; rst = 1;
    step(); run_at("rst halt", 32'h0);
    chk("rst retired", retired, 32'd0);
    rst = 0; redirect_en = 1; redirect_target = 32'h32;
    step(); stopped("fault 32", 32'h0, 1'b0);
    step(); stopped("fault hold", 32'h0, 1'b0);
    chk("fault retired", retired, ret(1));
    rst = 1; redirect_en = 0;
    step(); run_at("rst fault", 32'h0);
    rst = 0; redirect_en = 1; redirect_target = 32'h0040_0000;
    step(); stopped("fault range", 32'h0, 1'b0);
    rst = 1; redirect_en = 0;
    step(); rst = 0; redirect_en = 1; redirect_target = 32'h003F_FFFC;
    step(); run_at("top word", 32'h003F_FFFC);
    redirect_en = 0;
    step(); stopped("wrap fault", 32'h003F_FFFC, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
